moonbase_sram_bridge: RTL and testbench

MOONBASE_SRAM_BRIDGE -- requirements
Module: moonbase_sram_bridge

---
 rtl/moonbase_pkg.sv | 24 ++
 rtl/moonbase_bus_decode.sv | 42 ++++
 rtl/moonbase_sram_bridge.sv | 179 +++++++++++++++++
 tb/tb_moonbase_sram_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moonbase_pkg.sv
// Shared definitions for the moonbase CPU-pin-bus to SRAM bridge.
// Covers the FSM states, the bus bit positions and the address geometry.
package moonbase_pkg;

  localparam int unsigned AddrW = 12;
  localparam int unsigned HalfW = AddrW / 2;

  localparam int unsigned BitAddrStb = 7;
  localparam int unsigned BitSel     = 6;
  localparam int unsigned BitWeN     = 5;
  localparam int unsigned BitDataStb = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
  } wr_req_t;

endpackage

// File: rtl/moonbase_bus_decode.sv
// Registers the CPU pin bus and decodes the registered copy into one-cycle
// strobes, so nothing on the memory side sees bus_in combinationally.
module moonbase_bus_decode
  import moonbase_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bus_in,
  output logic             addr_we_hi,
  output logic             addr_we_lo,
  output logic             tmp_we,
  output logic             commit,
  output logic [HalfW-1:0] addr_val,
  output logic [3:0]       nib
);

  logic [7:0] bus_q;
  logic       data_wr;
  logic       unused_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q <= '0;
    end else begin
      bus_q <= bus_in;
    end
  end

  // The data strobe carries no extra meaning here; we_n alone qualifies writes.
  assign unused_stb = bus_q[BitDataStb];

  always_comb begin
    data_wr    = !bus_q[BitAddrStb] && !bus_q[BitWeN];
    addr_we_hi = bus_q[BitAddrStb] && bus_q[BitSel];
    addr_we_lo = bus_q[BitAddrStb] && !bus_q[BitSel];
    tmp_we     = data_wr && !bus_q[BitSel];
    commit     = data_wr && bus_q[BitSel];
    addr_val   = bus_q[HalfW-1:0];
    nib        = bus_q[3:0];
  end

endmodule

// File: rtl/moonbase_sram_bridge.sv
// Bridges the nibble-wide CPU pin bus to a byte-wide handshaked SRAM port,
// with one buffered write, read refresh on address change and an ack timeout.
module moonbase_sram_bridge
  import moonbase_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bus_in,
  output logic [3:0]       nib_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AddrW-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             err_overrun,
  output logic             err_timeout
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ACK_TIMEOUT - 1);

  logic             addr_we_hi, addr_we_lo, tmp_we, commit;
  logic [HalfW-1:0] addr_val;
  logic [3:0]       nib;

  state_e           state_q, state_d;
  logic [HalfW-1:0] addr_hi_q, addr_hi_d, addr_lo_q, addr_lo_d;
  logic [3:0]       tmp_q, tmp_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             pend_valid_q, pend_valid_d;
  wr_req_t          pend_q, pend_d;
  logic             refresh_q, refresh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mem_we_q, mem_we_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             err_overrun_q, err_overrun_d;
  logic             err_timeout_q, err_timeout_d;

  logic [AddrW-1:0] cur_addr;
  wr_req_t          commit_req;
  logic             refresh_req;

  moonbase_bus_decode u_bus_decode (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .addr_we_hi (addr_we_hi),
    .addr_we_lo (addr_we_lo),
    .tmp_we     (tmp_we),
    .commit     (commit),
    .addr_val   (addr_val),
    .nib        (nib)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      addr_hi_q     <= '0;
      addr_lo_q     <= '0;
      tmp_q         <= '0;
      rdata_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_q        <= '0;
      refresh_q     <= 1'b0;
      cnt_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_hi_q     <= addr_hi_d;
      addr_lo_q     <= addr_lo_d;
      tmp_q         <= tmp_d;
      rdata_q       <= rdata_d;
      pend_valid_q  <= pend_valid_d;
      pend_q        <= pend_d;
      refresh_q     <= refresh_d;
      cnt_q         <= cnt_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_hi_d     = addr_hi_q;
    addr_lo_d     = addr_lo_q;
    tmp_d         = tmp_q;
    rdata_d       = rdata_q;
    pend_valid_d  = pend_valid_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;

    if (addr_we_hi) addr_hi_d = addr_val;
    if (addr_we_lo) addr_lo_d = addr_val;
    if (tmp_we)     tmp_d     = nib;

    // cur_addr already includes this cycle's address phase.
    cur_addr         = {addr_hi_d, addr_lo_d};
    commit_req.addr  = {addr_hi_q, addr_lo_q};
    commit_req.data  = {nib, tmp_q};
    refresh_req      = refresh_q || addr_we_hi || addr_we_lo;
    refresh_d        = refresh_req;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q || commit) begin
          state_d  = StWrite;
          mem_we_d = 1'b1;
          cnt_d    = '0;
          if (pend_valid_q) begin
            // Slot drains and refills in the same cycle if a commit arrives now.
            mem_addr_d   = pend_q.addr;
            mem_wdata_d  = pend_q.data;
            pend_valid_d = commit;
            if (commit) pend_d = commit_req;
          end else begin
            mem_addr_d  = commit_req.addr;
            mem_wdata_d = commit_req.data;
          end
        end else if (refresh_req) begin
          state_d    = StRead;
          mem_we_d   = 1'b0;
          mem_addr_d = cur_addr;
          refresh_d  = 1'b0;
          cnt_d      = '0;
        end
      end
      StRead, StWrite: begin
        if (commit) begin
          if (pend_valid_q) begin
            err_overrun_d = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_d       = commit_req;
          end
        end
        if (mem_ack) begin
          state_d = StIdle;
          // Stale data is dropped; the pending refresh re-reads the new address.
          if (mem_addr_q == cur_addr) begin
            rdata_d = (state_q == StRead) ? mem_rdata : mem_wdata_q;
          end
        end else if (cnt_q == LastCnt) begin
          state_d       = StIdle;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_req     = (state_q != StIdle);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = (state_q != StIdle) || pend_valid_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;
  assign nib_out     = bus_in[BitSel] ? rdata_q[3:0] : rdata_q[7:4];

endmodule

// File: tb/tb_moonbase_sram_bridge.sv
// Self-checking bench: directed scenarios, a nibble-mux vector table and
// randomized bus traffic compared every cycle against a reference model.
module tb_moonbase_sram_bridge;

  localparam int unsigned AckTo = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_in;
  logic [3:0]  nib_out;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        busy, err_overrun, err_timeout;

  moonbase_sram_bridge #(.ACK_TIMEOUT(AckTo)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_in      (bus_in),
    .nib_out     (nib_out),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Memory side: byte array plus an access log filled by the responder.
  logic [7:0] mem [4096];
  typedef struct {bit we; logic [11:0] a; logic [7:0] d;} acc_t;
  acc_t log_q[$];
  int   ack_delay = 0;
  bit   ack_never = 0;
  int   wcnt = 0;

  // Reference model state, kept in terms of the bus protocol.
  typedef struct {logic [11:0] a; logic [7:0] d;} wr_t;
  wr_t        m_pend[$];
  int         m_mode;  // 0 idle, 1 reading, 2 writing
  int         m_age;
  logic [5:0] m_hi, m_lo;
  logic [3:0] m_tmp;
  logic [7:0] m_rdata, m_wdata, m_prev;
  logic [11:0] m_addr;
  bit         m_we, m_refresh, m_ovr, m_tmo;

  typedef struct {logic [7:0] bus; logic [3:0] nib; logic busy;} vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_mode = 0; m_age = 0; m_hi = 0; m_lo = 0; m_tmp = 0; m_rdata = 0;
    m_wdata = 0; m_prev = 0; m_addr = 0; m_we = 0; m_refresh = 0; m_ovr = 0; m_tmo = 0;
  endtask

  // Advances the model by one clock edge; b is the bus value sampled at that edge.
  task automatic model_edge(input logic [7:0] b, input logic ack);
    logic [7:0]  p;
    logic [5:0]  nhi, nlo;
    logic [11:0] cur;
    bit          ap, cm, tw, want;
    wr_t         c, w;
    p = m_prev;
    m_prev = b;
    ap  = p[7];
    cm  = !p[7] && !p[5] && p[6];
    tw  = !p[7] && !p[5] && !p[6];
    nhi = (ap && p[6]) ? p[5:0] : m_hi;
    nlo = (ap && !p[6]) ? p[5:0] : m_lo;
    cur = {nhi, nlo};
    c.a = {m_hi, m_lo};
    c.d = {p[3:0], m_tmp};
    want = m_refresh || ap;
    if (m_mode == 0) begin
      if (m_pend.size() > 0 || cm) begin
        if (m_pend.size() > 0) begin
          w = m_pend.pop_front();
          if (cm) m_pend.push_back(c);
        end else begin
          w = c;
        end
        m_mode = 2; m_addr = w.a; m_wdata = w.d; m_we = 1; m_age = 0;
        m_refresh = want;
      end else if (want) begin
        m_mode = 1; m_addr = cur; m_we = 0; m_age = 0; m_refresh = 0;
      end
    end else begin
      if (cm) begin
        if (m_pend.size() == 0) m_pend.push_back(c);
        else m_ovr = 1;
      end
      m_refresh = want;
      if (ack) begin
        if (m_addr == cur) m_rdata = (m_mode == 2) ? m_wdata : mem[m_addr];
        m_mode = 0;
      end else if (m_age == AckTo - 1) begin
        m_tmo = 1; m_mode = 0;
      end else begin
        m_age++;
      end
    end
    if (tw) m_tmp = p[3:0];
    m_hi = nhi;
    m_lo = nlo;
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req, m_mode != 0);
    chk("busy", busy, (m_mode != 0) || (m_pend.size() > 0));
    chk("err_overrun", err_overrun, m_ovr);
    chk("err_timeout", err_timeout, m_tmo);
    chk("nib_out", nib_out, bus_in[6] ? m_rdata[3:0] : m_rdata[7:4]);
    if (m_mode != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_mode == 2) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic respond();
    mem_rdata = 8'($urandom);
    if (!mem_req) begin
      mem_ack = 0; wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 0;
    end else if (!ack_never && wcnt >= ack_delay) begin
      mem_ack = 1;
      if (mem_we) mem[mem_addr] = mem_wdata;
      else mem_rdata = mem[mem_addr];
      log_q.push_back('{we: mem_we, a: mem_addr, d: mem_we ? mem_wdata : mem[mem_addr]});
    end else begin
      wcnt++;
    end
  endtask

  task automatic step(input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    bus_in = b;
    respond();
    model_edge(b, mem_ack);
  endtask

  task automatic drain();
    int k = 0;
    while (!(m_mode == 0 && m_pend.size() == 0 && !m_refresh && !m_prev[7] && m_prev[5])
           && k < 200) begin
      step(8'h20);
      k++;
    end
    chk("drain_bound", k < 200, 1);
    step(8'h20);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1; mem_ack = 0; wcnt = 0; bus_in = 8'h20;
    model_edge(8'h20, 1'b0);
  endtask

  function automatic int count_writes();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we) n++;
    return n;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         cnt, k, r;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    vecs[0] = '{bus: 8'h20, nib: 4'h5, busy: 1'b0};
    vecs[1] = '{bus: 8'h60, nib: 4'hE, busy: 1'b0};
    vecs[2] = '{bus: 8'h2F, nib: 4'h5, busy: 1'b0};
    vecs[3] = '{bus: 8'h7F, nib: 4'hE, busy: 1'b0};
    vecs[4] = '{bus: 8'h35, nib: 4'h5, busy: 1'b0};
    vecs[5] = '{bus: 8'h70, nib: 4'hE, busy: 1'b0};

    rst = 0; bus_in = 8'h20; mem_ack = 0; mem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    release_reset();

    // Address 0xA95 then write 0xC7, read back nibbles.
    ack_delay = 0;
    log_q.delete();
    step(8'hEA); step(8'h95); step(8'h07); step(8'h4C);
    drain();
    chk("wr_count", count_writes(), 1);
    foreach (log_q[i]) if (log_q[i].we) begin
      chk("wr_addr", log_q[i].a, 12'hA95);
      chk("wr_data", log_q[i].d, 8'hC7);
    end
    step(8'h20); #1 chk("nib_hi_C", nib_out, 4'hC);
    step(8'h60); #1 chk("nib_lo_7", nib_out, 4'h7);

    // Read 0x5E back from 0x123.
    mem[12'h123] = 8'h5E;
    log_q.delete();
    step(8'hC4); step(8'hA3);
    drain();
    chk("rd_last_addr", log_q[log_q.size()-1].a, 12'h123);
    chk("rd_last_we", log_q[log_q.size()-1].we, 0);
    step(8'h20); #1 chk("nib_hi_5", nib_out, 4'h5);
    step(8'h60); #1 chk("nib_lo_E", nib_out, 4'hE);

    foreach (vecs[i]) begin
      step(vecs[i].bus);
      #1;
      chk($sformatf("vec%0d_nib", i), nib_out, vecs[i].nib);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // Slow read with two commits: one buffered, one dropped.
    ack_delay = 10;
    log_q.delete();
    step(8'hC4); step(8'h20); step(8'h03); step(8'h49); step(8'h05); step(8'h4A);
    drain();
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_wr_count", count_writes(), 1);
    chk("ovr_log_size", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("ovr_first_is_read", log_q[0].we, 0);
      chk("ovr_write_addr", log_q[1].a, 12'h123);
      chk("ovr_write_data", log_q[1].d, 8'h93);
    end

    // Memory never acks: access is abandoned after the timeout.
    ack_never = 1;
    step(8'hC4);
    cnt = 0; k = 0;
    while (!(cnt > 0 && !mem_req) && k < 60) begin
      step(8'h20);
      if (mem_req) cnt++;
      k++;
    end
    chk("tmo_req_cycles", cnt, AckTo);
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_busy", busy, 0);
    ack_never = 0;

    // Reset while a request is outstanding.
    ack_delay = 5;
    step(8'h84); step(8'h20); step(8'h20);
    chk("pre_reset_req", mem_req, 1);
    #2 rst = 0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovr", err_overrun, 0);
    chk("arst_tmo", err_timeout, 0);
    chk("arst_nib", nib_out, 0);
    mem_ack = 0;
    model_reset();
    release_reset();

    // Randomized traffic against the model.
    ack_delay = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        ack_delay = $urandom_range(0, 4);
        ack_never = ($urandom_range(0, 7) == 0);
      end
      r = $urandom_range(0, 99);
      b = 8'($urandom);
      if (r < 20) begin
        b[7] = 1'b1;
      end else if (r < 40) begin
        b[7] = 1'b0; b[6] = 1'b0; b[5] = 1'b0;
      end else if (r < 55) begin
        b[7] = 1'b0; b[6] = 1'b1; b[5] = 1'b0;
      end else begin
        b[7] = 1'b0; b[5] = 1'b1;
      end
      step(b);
    end
    ack_never = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
